// File: rtl/arth_op_sequencer.sv
// Command-side driver for the arithmetic unit. It issues one operation, waits a
// fixed per-opcode latency, then returns the captured answer over a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a request; operands latch when one is accepted
// ISSUE | newop high for this single cycle; latency counter loads
// WAIT  | counting down the opcode latency; answer captured at zero
// DONE  | result held until downstream accepts it
module arth_op_sequencer #(
    parameter int WIDTH   = 17,
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 18,
    parameter int LAT_DIV = 18
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic [WIDTH-1:0] V1,
    output logic [WIDTH-1:0] V2,
    output logic [1:0]       opcode,
    output logic             newop,
    input  logic [WIDTH-1:0] answer,
    input  logic             ovw,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_answer,
    output logic             res_ovw,
    output logic             res_err,
    output logic             busy
);

    localparam int LAT_MAX = (LAT_ADD > LAT_MUL) ? ((LAT_ADD > LAT_DIV) ? LAT_ADD : LAT_DIV)
                                                 : ((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV);
    localparam int CW = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    function automatic logic [CW-1:0] lat_load(input logic [1:0] op);
        case (op)
            2'b01:   lat_load = CW'(LAT_MUL - 1);
            2'b10:   lat_load = CW'(LAT_DIV - 1);
            default: lat_load = CW'(LAT_ADD - 1);
        endcase
    endfunction

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            V1         <= '0;
            V2         <= '0;
            opcode     <= '0;
            newop      <= 1'b0;
            res_valid  <= 1'b0;
            res_answer <= '0;
            res_ovw    <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            newop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        V1     <= req_a;
                        V2     <= req_b;
                        opcode <= req_op;
                        if (req_op == 2'b11) begin
                            // Illegal opcode never reaches the arithmetic unit.
                            res_answer <= '0;
                            res_ovw    <= 1'b0;
                            res_err    <= 1'b1;
                            res_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            newop <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= lat_load(opcode);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        res_answer <= answer;
                        res_ovw    <= ovw;
                        res_err    <= 1'b0;
                        res_valid  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arth_op_sequencer.sv
// Directed bench for arth_op_sequencer with a latency-accurate arithmetic unit model
// that only presents a valid answer/ovw in the exact capture cycle.
module tb_arth_op_sequencer;
    localparam int W = 17;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [1:0]   req_op = '0;
    logic         req_ready, newop, res_valid, res_ovw, res_err, busy;
    logic [W-1:0] V1, V2, res_answer;
    logic [1:0]   opcode;
    logic [W-1:0] answer;
    logic         ovw;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int since = 0;

    arth_op_sequencer #(.WIDTH(W), .LAT_ADD(2), .LAT_MUL(18), .LAT_DIV(18)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .V1(V1), .V2(V2), .opcode(opcode), .newop(newop),
        .answer(answer), .ovw(ovw),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_answer(res_answer), .res_ovw(res_ovw), .res_err(res_err),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Arithmetic unit model: cycles since newop; answer valid only when since == latency.
    always @(posedge clock) begin
        if (reset)                         since <= 0;
        else if (newop)                    since <= 1;
        else if (since != 0 && since < 100) since <= since + 1;
    end

    logic [W-1:0] model_res;
    logic         model_ovw;
    int           model_lat;
    always_comb begin
        model_lat = 2;
        model_res = V1 + V2;
        model_ovw = 1'b0;
        if (opcode == 2'b01) begin
            model_lat = 18;
            model_res = V1 * V2;
            model_ovw = 1'b1;
        end else if (opcode == 2'b10) begin
            model_lat = 18;
            model_res = (V2 != '0) ? V1 / V2 : '0;
        end
        answer = (since == model_lat) ? model_res : 17'h15555;
        ovw    = (since == model_lat) ? model_ovw : 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_res(output int k, output int extra, output int unstable);
        logic [W-1:0] h1, h2;
        logic [1:0]   ho;
        h1 = V1; h2 = V2; ho = opcode;
        k = 0; extra = 0; unstable = 0;
        while (res_valid !== 1'b1 && k < 60) begin
            @(negedge clock);
            k++;
            if (newop === 1'b1) extra++;
            if (V1 !== h1 || V2 !== h2 || opcode !== ho) unstable++;
        end
    endtask

    int           k, extra, unstable, bad, seen, idx, nn, t;
    int           nt[4];
    logic [W-1:0] got[3];
    logic [W-1:0] a_t[3] = '{17'd10, 17'd65535, 17'd131071};
    logic [W-1:0] b_t[3] = '{17'd20, 17'd2, 17'd1};
    logic [W-1:0] e_t[3] = '{17'd30, 17'd65537, 17'd0};

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_outs", {V1, V2, opcode, newop, res_valid, res_answer, res_ovw, res_err}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", {req_ready, busy}, {1'b1, 1'b0});

        // add 5+7 with back-pressure on the result
        req_a = 17'd5; req_b = 17'd7; req_op = 2'b00; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0; req_a = 17'd1; req_b = 17'd2; req_op = 2'b01;
        chk("add_newop", {newop, req_ready, busy}, {1'b1, 1'b0, 1'b1});
        chk("add_hold", {V1, V2, opcode}, {17'd5, 17'd7, 2'd0});
        wait_res(k, extra, unstable);
        chk("add_lat", k, 3);
        chk("add_newop_once", extra, 0);
        chk("add_res", {res_answer, res_ovw, res_err}, {17'd12, 1'b0, 1'b0});
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin req_valid = 1'b1; req_a = 17'd99; req_op = 2'b00; end
            if (i == 4) req_valid = 1'b0;
            @(negedge clock);
            if (res_answer !== 17'd12 || req_ready !== 1'b0 || res_valid !== 1'b1 || newop !== 1'b0) bad++;
        end
        chk("bp_stable", bad, 0);
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        chk("bp_release", {req_ready, res_valid}, {1'b1, 1'b0});
        chk("bp_ignored", {V1, newop}, {17'd5, 1'b0});

        // multiply 300*400, ovw set by the model
        req_a = 17'd300; req_b = 17'd400; req_op = 2'b01; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0; req_a = 17'd7; req_b = 17'd8; req_op = 2'b10;
        chk("mul_newop", newop, 1'b1);
        wait_res(k, extra, unstable);
        chk("mul_lat", k, 19);
        chk("mul_newop_once", extra, 0);
        chk("mul_stable", unstable, 0);
        chk("mul_res", {res_answer, res_ovw, res_err}, {17'd120000, 1'b1, 1'b0});
        chk("mul_hold", {V1, V2, opcode}, {17'd300, 17'd400, 2'd1});
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;

        // illegal opcode
        req_a = 17'd9; req_b = 17'd9; req_op = 2'b11; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("ill_newop", newop, 1'b0);
        chk("ill_valid", res_valid, 1'b1);
        chk("ill_res", {res_answer, res_ovw, res_err}, {17'd0, 1'b0, 1'b1});
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        chk("ill_done", {req_ready, res_valid, newop}, {1'b1, 1'b0, 1'b0});

        // reset during WAIT of a divide
        req_a = 17'd100; req_b = 17'd5; req_op = 2'b10; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_outs", {V1, V2, opcode, newop, res_valid, res_answer, res_ovw, res_err}, 64'd0);
        chk("midrst_idle", {req_ready, busy}, {1'b1, 1'b0});
        seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (res_valid !== 1'b0 || newop !== 1'b0) seen++;
        end
        chk("midrst_quiet", seen, 0);

        // fresh add with res_ready already high: handshake in the rising cycle
        res_ready = 1'b1;
        req_a = 17'd1000; req_b = 17'd24; req_op = 2'b00; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("post_newop", newop, 1'b1);
        wait_res(k, extra, unstable);
        chk("post_lat", k, 3);
        chk("post_res", {res_answer, res_ovw, res_err}, {17'd1024, 1'b0, 1'b0});
        @(negedge clock);
        chk("post_handshake", {req_ready, res_valid}, {1'b1, 1'b0});

        // back-to-back adds, req_valid held high
        req_a = a_t[0]; req_b = b_t[0]; req_op = 2'b00; req_valid = 1'b1;
        idx = 0; nn = 0; t = 0;
        while (idx < 3 && t < 100) begin
            @(negedge clock);
            t++;
            if (newop === 1'b1) begin
                if (nn < 4) nt[nn] = cyc;
                nn++;
            end
            if (res_valid === 1'b1) begin
                got[idx] = res_answer;
                idx++;
                if (idx < 3) begin req_a = a_t[idx]; req_b = b_t[idx]; end
                else req_valid = 1'b0;
            end
        end
        chk("b2b_results", idx, 3);
        chk("b2b_newops", nn, 3);
        chk("b2b_space01", nt[1] - nt[0], 5);
        chk("b2b_space12", nt[2] - nt[1], 5);
        for (int i = 0; i < 3; i++) chk($sformatf("b2b_res%0d", i), got[i], e_t[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/arth_op_sequencer.md
Name: arth_op_sequencer

Overview:
- Command-side driver for the arithmetic unit; it sits on the opposite end of that unit's V1/V2/opcode/newop interface.
- Accepts one operation at a time from upstream control (keypad/display controller) over a valid/ready handshake.
- Presents operands and opcode to the arithmetic unit and pulses newop for one cycle.
- The arithmetic unit has no done flag, so the block waits a per-opcode latency, captures answer/ovw, and returns them over a valid/ready result handshake.

Parameters:
- WIDTH, 17, operand/result width in bits.
- LAT_ADD, 2, cycles from newop to valid answer for opcode 2'b00 (must be >= 1).
- LAT_MUL, 18, same for opcode 2'b01.
- LAT_DIV, 18, same for opcode 2'b10.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  upstream operation request.
- req_ready  output  1  block can accept a request.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- req_op  input  2  opcode: 00 add, 01 multiply, 10 divide, 11 illegal.
- V1  output  WIDTH  operand A to the arithmetic unit.
- V2  output  WIDTH  operand B to the arithmetic unit.
- opcode  output  2  opcode to the arithmetic unit.
- newop  output  1  one-cycle start pulse to the arithmetic unit.
- answer  input  WIDTH  result from the arithmetic unit.
- ovw  input  1  overflow from the arithmetic unit.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts the result.
- res_answer  output  WIDTH  captured result.
- res_ovw  output  1  captured overflow.
- res_err  output  1  request used an illegal opcode.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high): state returns to IDLE from any state, including mid-operation.
  - All registered outputs clear to 0: V1, V2, opcode, newop, res_valid, res_answer, res_ovw, res_err.
  - Latency counter clears to 0.
  - req_ready=1 in the first cycle after reset deasserts.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid=1, latch req_a->V1, req_b->V2, req_op->opcode.
  - If req_op=11: load res_answer=0, res_ovw=0, res_err=1 and go to DONE. No newop is issued.
  - Otherwise go to ISSUE.
- ISSUE (one cycle, call it T):
  - newop=1 for this cycle only.
  - Load the counter with LAT_x-1 for the latched opcode, then go to WAIT.
- WAIT (cycles T+1 .. T+LAT_x):
  - If counter=0: capture answer->res_answer, ovw->res_ovw, set res_err=0, go to DONE.
  - Otherwise decrement the counter.
  - Result: res_valid rises in cycle T+LAT_x+1.
- DONE:
  - res_valid=1; res_* are held stable.
  - On res_ready=1, clear res_valid and go to IDLE. req_ready=1 in the next cycle.
  - res_ready may already be high when res_valid rises; the handshake then completes in that same cycle.
- Operand stability: V1, V2 and opcode change only in IDLE on an accepted request. They are held through ISSUE, WAIT and DONE, because the arithmetic unit may sample them during its whole latency.
- newop is never high outside ISSUE and never for two consecutive cycles.
- req_ready=0 in ISSUE, WAIT and DONE. req_valid is ignored there, with no queuing.
- req_a/req_b/req_op may change freely while req_ready=0.
- Widths: straight pass-through, with no sign extension or truncation; signed interpretation belongs to the arithmetic unit.
- Throughput: one operation per LAT_x+3 cycles minimum (IDLE accept, ISSUE, LAT_x WAIT cycles, DONE with res_ready already high).
- ovw is sampled only in the capture cycle; any ovw glitch at other times is ignored.

Test Plan:
- Reset release, then req_valid with a=5, b=7, op=00 (LAT_ADD=2):
  - newop is high exactly one cycle, in the cycle after acceptance.
  - With the arithmetic unit (or a model) returning 12, res_valid rises 3 cycles after newop with res_answer=12, res_ovw=0, res_err=0.
- op=01, a=300, b=400, model sets ovw=1 with answer=120000 mod 2^17:
  - res_valid rises at newop+19 cycles with res_ovw=1.
  - V1=300, V2=400 and opcode=01 are held constant from acceptance through DONE.
- op=11, a=9, b=9:
  - newop never asserts.
  - res_valid rises the cycle after acceptance with res_err=1, res_answer=0.
- Back-pressure: hold res_ready=0 for 10 cycles after res_valid.
  - res_answer stays stable and req_ready stays 0.
  - A req_valid pulse during this window is ignored, with no newop.
  - Release res_ready: req_ready returns the next cycle.
- Reset mid-operation: assert reset during WAIT for op=10.
  - All outputs are 0 the next cycle and no res_valid ever appears.
  - A fresh add request afterwards completes normally.
- Back-to-back: res_ready tied high and req_valid held high with changing operands.
  - Each request completes, newop pulses are spaced LAT_ADD+3 cycles apart, and the results match the model in order.
